updown_cnt_param: RTL

Parametrised up/down modulo counter: the next-generation successor to the fixed 4-bit up counter. It counts within 0..MODULO-1 in either direction, supports parallel load, and can either wrap or saturate at the range ends. It reports a one-cycle terminal-count pulse and a sticky overflow flag. It serves as the general counting primitive for timers, address generators and event counters in the design.

---
 rtl/updown_cnt_param.sv | 108 ++++++++++
 1 files changed

// File: rtl/updown_cnt_param.sv
// updown_cnt_param: parametrised up/down modulo counter.
//
// Counts within 0..MODULO-1 in either direction, with synchronous parallel
// load (clamped to the top of the range) and a choice of wrap or saturate
// behaviour at the range ends. A boundary event (stepping past either end)
// raises a one-cycle terminal-count pulse and sets a sticky overflow flag.
//
// Parameters:
//   WIDTH    counter width in bits (2..32)
//   MODULO   number of counter states (2..2^WIDTH)
//   SATURATE 0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports:
//   clk      rising-edge clock
//   a_reset  asynchronous active-high reset, clears all state
//   s_reset  synchronous active-high reset, clears all state
//   start    count enable, one step per clock while high
//   up       direction when stepping: 1 = increment, 0 = decrement
//   load     synchronous parallel load (wins over start)
//   load_val value to load, clamped to MODULO-1
//   count    current count (registered)
//   tc       terminal-count pulse (registered)
//   ovf      sticky boundary-hit flag (registered)

module updown_cnt_param #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULO   = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             a_reset,
  input  logic             s_reset,
  input  logic             start,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // Top of the range held at WIDTH+1 bits so MODULO = 2^WIDTH still fits.
  localparam longint unsigned MaxL   = MODULO - 1;
  localparam logic [WIDTH:0]  MaxExt = MaxL[WIDTH:0];
  localparam logic [WIDTH-1:0] MaxVal = MaxExt[WIDTH-1:0];
  localparam logic [WIDTH-1:0] One    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] load_ext;
  logic           at_max;
  logic           at_min;
  logic           boundary;

  always_comb begin
    count_ext = {1'b0, count_q};
    load_ext  = {1'b0, load_val};
    at_max    = (count_ext == MaxExt);
    at_min    = (count_ext == '0);
    // A step that would leave the range; only meaningful in a stepping cycle.
    boundary  = up ? at_max : at_min;

    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;

    if (s_reset) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_ext > MaxExt) ? MaxVal : load_val;
      ovf_d   = 1'b0;
    end else if (start) begin
      if (boundary) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (SATURATE) begin
          count_d = count_q;
        end else begin
          count_d = up ? '0 : MaxVal;
        end
      end else begin
        // Range check above guarantees these never leave 0..MODULO-1.
        count_d = up ? (count_q + One) : (count_q - One);
      end
    end
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule
